// File: rtl/ddr_sdram_ex_driver_ctrl_pkg.sv
// Shared types and helpers for the DDR SDRAM example-design self-test driver.
package ddr_sdram_ex_driver_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int LFSR_W = 8;

    function automatic logic [LFSR_W-1:0] lane_seed(input int seed_base, input int lane);
        return LFSR_W'((seed_base + lane) % 256);
    endfunction

endpackage

// File: rtl/ddr_sdram_ex_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1); reseeds to SEED whenever enable is low.
module ddr_sdram_ex_lfsr8
    import ddr_sdram_ex_driver_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pause,
    input  logic              load,
    input  logic [LFSR_W-1:0] ldata,
    output logic [LFSR_W-1:0] data
);

    logic [LFSR_W-1:0] data_next;

    always_comb begin
        data_next = {data[LFSR_W-2:0], 1'b0} ^ (data[LFSR_W-1] ? 8'h1D : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            data <= SEED;
        end else if (load) begin
            data <= ldata;
        end else if (!pause) begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/ddr_sdram_ex_driver_ctrl.sv
// Write/read-back self-test sequencer with sticky per-byte pass-not-fail.
// Define DDR_EX_DRIVER_LOOP_EN to restart a new pass automatically after DONE.
module ddr_sdram_ex_driver_ctrl
    import ddr_sdram_ex_driver_ctrl_pkg::*;
#(
    parameter int BYTES     = 2,
    parameter int ADDR_W    = 8,
    parameter int NUM_ADDR  = 256,
    parameter int SEED_BASE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 local_ready,
    output logic                 local_write_req,
    output logic                 local_read_req,
    output logic [ADDR_W-1:0]    local_addr,
    output logic [8*BYTES-1:0]   local_wdata,
    input  logic [8*BYTES-1:0]   local_rdata,
    input  logic                 local_rdata_valid,
    output logic [BYTES-1:0]     pnf_per_byte,
    output logic                 pnf,
    output logic                 test_complete
);

    localparam int CNT_W = ADDR_W + 1;

    state_t             state, state_next;
    logic               wr_next, rd_next, done_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [BYTES-1:0]   pnf_next;
    logic [CNT_W-1:0]   rcv_cnt, cnt_next;
    logic [8*BYTES-1:0] cmp_data;
    logic [BYTES-1:0]   lane_mismatch;
    logic               lfsr_en, wr_accept, rd_accept, checking, last_addr, rx_done;

    // Reset is folded into the enable so both LFSR sets come out of reset at their seeds.
    assign lfsr_en   = !reset && (state != IDLE) && (state != DONE);
    assign wr_accept = local_write_req && local_ready;
    assign rd_accept = local_read_req && local_ready;
    assign checking  = (state == READ) || (state == WAIT_RD);
    assign last_addr = (local_addr == ADDR_W'(NUM_ADDR - 1));
    assign pnf       = &pnf_per_byte;

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        ddr_sdram_ex_lfsr8 #(.SEED(lane_seed(SEED_BASE, i))) u_wr_lfsr (
            .clk    (clk),
            .reset_n(1'b1),
            .enable (lfsr_en),
            .pause  (!wr_accept),
            .load   (1'b0),
            .ldata  ('0),
            .data   (local_wdata[8*i +: 8])
        );
        ddr_sdram_ex_lfsr8 #(.SEED(lane_seed(SEED_BASE, i))) u_cmp_lfsr (
            .clk    (clk),
            .reset_n(1'b1),
            .enable (lfsr_en),
            .pause  (!(checking && local_rdata_valid)),
            .load   (1'b0),
            .ldata  ('0),
            .data   (cmp_data[8*i +: 8])
        );
        assign lane_mismatch[i] = (local_rdata[8*i +: 8] != cmp_data[8*i +: 8]);
    end

    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        rd_next    = 1'b0;
        addr_next  = local_addr;
        pnf_next   = pnf_per_byte;
        cnt_next   = rcv_cnt;

        if (checking && local_rdata_valid) begin
            cnt_next = rcv_cnt + CNT_W'(1);
            pnf_next = pnf_per_byte & ~lane_mismatch;
        end
        rx_done = (cnt_next == CNT_W'(NUM_ADDR));

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WRITE;
                    wr_next    = 1'b1;
                    addr_next  = '0;
                    cnt_next   = '0;
                    pnf_next   = '1;
                end
            end
            WRITE: begin
                wr_next = 1'b1;
                if (wr_accept) begin
                    if (last_addr) begin
                        state_next = READ;
                        wr_next    = 1'b0;
                        rd_next    = 1'b1;
                        addr_next  = '0;
                    end else begin
                        addr_next = local_addr + ADDR_W'(1);
                    end
                end
            end
            READ: begin
                rd_next = 1'b1;
                if (rd_accept) begin
                    if (last_addr) begin
                        // The final beat can return in the same cycle as the last accept.
                        state_next = rx_done ? DONE : WAIT_RD;
                        rd_next    = 1'b0;
                        addr_next  = '0;
                    end else begin
                        addr_next = local_addr + ADDR_W'(1);
                    end
                end
            end
            WAIT_RD: begin
                if (rx_done) state_next = DONE;
            end
            DONE: begin
`ifdef DDR_EX_DRIVER_LOOP_EN
                state_next = WRITE;
                wr_next    = 1'b1;
                addr_next  = '0;
                cnt_next   = '0;
                if (start) pnf_next = '1;
`else
                if (start) begin
                    state_next = WRITE;
                    wr_next    = 1'b1;
                    addr_next  = '0;
                    cnt_next   = '0;
                    pnf_next   = '1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            local_write_req <= 1'b0;
            local_read_req  <= 1'b0;
            local_addr      <= '0;
            pnf_per_byte    <= '1;
            rcv_cnt         <= '0;
            test_complete   <= 1'b0;
        end else begin
            state           <= state_next;
            local_write_req <= wr_next;
            local_read_req  <= rd_next;
            local_addr      <= addr_next;
            pnf_per_byte    <= pnf_next;
            rcv_cnt         <= cnt_next;
            test_complete   <= done_next;
        end
    end

endmodule

// File: tb/tb_ddr_sdram_ex_driver_ctrl.sv
// Directed self-checking bench for ddr_sdram_ex_driver_ctrl with a simple memory model.
module tb_ddr_sdram_ex_driver_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        local_ready = 1'b1;
    logic        local_write_req, local_read_req;
    logic [1:0]  local_addr;
    logic [15:0] local_wdata;
    logic [15:0] local_rdata = '0;
    logic        local_rdata_valid = 1'b0;
    logic [1:0]  pnf_per_byte;
    logic        pnf, test_complete;

    ddr_sdram_ex_driver_ctrl #(.BYTES(2), .ADDR_W(2), .NUM_ADDR(4), .SEED_BASE(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .local_ready      (local_ready),
        .local_write_req  (local_write_req),
        .local_read_req   (local_read_req),
        .local_addr       (local_addr),
        .local_wdata      (local_wdata),
        .local_rdata      (local_rdata),
        .local_rdata_valid(local_rdata_valid),
        .pnf_per_byte     (pnf_per_byte),
        .pnf              (pnf),
        .test_complete    (test_complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ready;
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic        chk_wd;
        logic [15:0] wd;
        logic        done;
        logic [1:0]  pnfb;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        int         due;
    } rd_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rx = 0;
    int          nwr = 0;
    int          nrd = 0;
    bit          corrupt_on = 1'b0;
    int          corrupt_addr = 2;
    bit          from_q = 1'b0;
    logic [15:0] mem [4];
    logic [15:0] exp_words [4];
    rd_t         rq [$];
    vec_t        vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample requests before the edge, update the memory model after it.
    task automatic tick();
        logic        wacc, racc, rv, hold_chk;
        logic [1:0]  a0;
        logic [15:0] wd0;
        rd_t         it;
        wacc     = local_write_req && local_ready;
        racc     = local_read_req && local_ready;
        rv       = local_rdata_valid && from_q;
        hold_chk = local_write_req && !local_ready;
        a0       = local_addr;
        wd0      = local_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (wacc === 1'b1) begin
            mem[a0] = wd0;
            nwr++;
        end
        if (racc === 1'b1) begin
            rq.push_back('{a: a0, due: cyc + lat - 1});
            nrd++;
        end
        if (rv) rx++;
        if (hold_chk === 1'b1 && local_write_req && !reset)
            chk("stall_hold", {14'd0, local_addr, local_wdata}, {14'd0, a0, wd0});
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            it = rq.pop_front();
            local_rdata_valid = 1'b1;
            local_rdata = mem[it.a] ^
                ((corrupt_on && (corrupt_addr < 0 || corrupt_addr == int'(it.a))) ? 16'hFF00 : 16'h0000);
            from_q = 1'b1;
        end else begin
            local_rdata_valid = 1'b0;
            local_rdata = 16'hDEAD;
            from_q = 1'b0;
        end
    endtask

    task automatic run_pass(input bit stall);
        bit fin;
        rx = 0; nwr = 0; nrd = 0;
        start = 1'b1; local_ready = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        for (int t = 0; t < 300 && !fin; t++) begin
            local_ready = (stall && local_write_req) ? (cyc % 3 == 0) : 1'b1;
            tick();
            chk("complete_timing", {31'd0, test_complete}, {31'd0, rx == 4});
            if (test_complete) fin = 1'b1;
        end
        local_ready = 1'b1;
        if (!fin) begin
            errors++;
            $display("FAIL pass_timeout: got test_complete=%b required 1", test_complete);
        end
    endtask

    task automatic chk_mem();
        for (int i = 0; i < 4; i++) chk($sformatf("mem_word%0d", i), mem[i], exp_words[i]);
    endtask

    initial begin
        int  pulses;
        bit  found;

        exp_words[0] = 16'h2120; exp_words[1] = 16'h4240;
        exp_words[2] = 16'h8480; exp_words[3] = 16'h151D;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;

        //              start ready wr rd addr chkwd wd        done pnfb
        vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 16'h2120, 1'b0, 2'b11};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 16'h4240, 1'b0, 2'b11};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 16'h8480, 1'b0, 2'b11};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 16'h151D, 1'b0, 2'b11};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 2'b11};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 2'b11};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 2'b11};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 2'b11};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'b11};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'b11};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'b11};

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_req", {30'd0, local_write_req, local_read_req}, 32'd0);
        chk("reset_addr", {30'd0, local_addr}, 32'd0);
        chk("reset_complete", {31'd0, test_complete}, 32'd0);
        chk("reset_pnf", {29'd0, pnf_per_byte, pnf}, 32'd7);
        chk("reset_wdata", {16'd0, local_wdata}, 32'h2120);

`ifdef DDR_EX_DRIVER_LOOP_EN
        corrupt_on = 1'b1; corrupt_addr = 2; lat = 1;
        start = 1'b1; tick(); start = 1'b0;
        pulses = 0;
        for (int t = 0; t < 300 && pulses < 3; t++) begin
            tick();
            if (test_complete) begin
                pulses++;
                corrupt_on = 1'b0;
                chk("loop_pnf", {31'd0, pnf}, 32'd0);
                chk("loop_pnfb", {30'd0, pnf_per_byte}, 32'd1);
                tick();
                chk("loop_pulse_width", {31'd0, test_complete}, 32'd0);
            end
        end
        chk("loop_pulses", pulses, 3);
        chk_mem();
`else
        for (int i = 0; i < 11; i++) begin
            start = vt[i].start;
            local_ready = vt[i].ready;
            tick();
            chk($sformatf("vec%0d_ctrl", i),
                {25'd0, local_write_req, local_read_req, local_addr, test_complete, pnf_per_byte},
                {25'd0, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].done, vt[i].pnfb});
            if (vt[i].chk_wd) chk($sformatf("vec%0d_wdata", i), {16'd0, local_wdata}, {16'd0, vt[i].wd});
        end
        start = 1'b0;
        chk_mem();

        // Spurious valid with garbage data while in DONE, then while in IDLE.
        local_rdata_valid = 1'b1; local_rdata = 16'h0000; from_q = 1'b0;
        tick();
        chk("spur_done", {30'd0, pnf_per_byte, test_complete}, 32'b111);
        reset = 1'b1; tick(); reset = 1'b0;
        local_rdata_valid = 1'b1; local_rdata = 16'h0000; from_q = 1'b0;
        tick();
        chk("spur_idle", {29'd0, pnf_per_byte, pnf}, 32'b111);

        corrupt_on = 1'b1; corrupt_addr = 2;
        run_pass(1'b0);
        chk("corrupt_pnfb", {30'd0, pnf_per_byte}, 32'b01);
        chk("corrupt_pnf", {31'd0, pnf}, 32'd0);
        corrupt_on = 1'b0;
        run_pass(1'b0);
        chk("clean_pnf", {29'd0, pnf_per_byte, pnf}, 32'b111);

        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        run_pass(1'b1);
        chk_mem();
        chk("stall_counts", {nwr[15:0], nrd[15:0]}, {16'd4, 16'd4});
        chk("stall_pnf", {31'd0, pnf}, 32'd1);

        lat = 6;
        run_pass(1'b0);
        chk("lat6_pnf", {29'd0, pnf_per_byte, pnf}, 32'b111);

        lat = 3;
        start = 1'b1; tick(); start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            tick();
            if (local_read_req && local_addr == 2'd2) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL mid_read_timeout: got read at addr %0d required addr 2", local_addr);
        end
        corrupt_on = 1'b1; corrupt_addr = -1;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_ctrl", {27'd0, local_write_req, local_read_req, test_complete, pnf_per_byte}, 32'b00011);
        chk("midrst_wdata", {16'd0, local_wdata}, 32'h2120);
        for (int t = 0; t < 10; t++) tick();
        chk("midrst_drain", {27'd0, local_write_req, local_read_req, test_complete, pnf_per_byte}, 32'b00011);
        corrupt_on = 1'b0; lat = 1;
        run_pass(1'b0);
        chk("after_rst_pnf", {29'd0, pnf_per_byte, pnf}, 32'b111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
